// File: rtl/track_readback.sv
// Tracker readback FIFO: captures 16-bit accumulator dumps and serves them one byte per toggle request.
// Define TRACK_READBACK_TAG_EN to prefix each word with a {overflow, seq[6:0]} tag byte.
module track_readback #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dump,
    input  logic [15:0]           accumulator,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);

`ifdef TRACK_READBACK_TAG_EN
    typedef enum logic [1:0] {ST_TAG, ST_LO, ST_HI} state_t;
    localparam state_t ST_IDLE = ST_TAG;
`else
    typedef enum logic {ST_LO, ST_HI} state_t;
    localparam state_t ST_IDLE = ST_LO;
`endif

    state_t                 state_q, state_d;
    logic                   req_q;
    logic                   ack_q, ack_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]            mem_q [DEPTH];
`ifdef TRACK_READBACK_TAG_EN
    logic [6:0]             seq_q, seq_d;
`endif

    logic        req;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic [15:0] head;

    assign req  = rd_req != req_q;
    assign full = count_q == COUNT_FULL;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        valid_d = valid_q;
        pop     = 1'b0;
        if (req) begin
            ack_d = ~ack_q;
            case (state_q)
`ifdef TRACK_READBACK_TAG_EN
                ST_TAG: begin
                    if (count_q != '0) begin
                        data_d  = {ovf_q, seq_q};
                        valid_d = 1'b1;
                        state_d = ST_LO;
                    end else begin
                        data_d  = 8'h00;
                        valid_d = 1'b0;
                    end
                end
                ST_LO: begin
                    data_d  = head[7:0];
                    valid_d = 1'b1;
                    state_d = ST_HI;
                end
`else
                ST_LO: begin
                    if (count_q != '0) begin
                        data_d  = head[7:0];
                        valid_d = 1'b1;
                        state_d = ST_HI;
                    end else begin
                        data_d  = 8'h00;
                        valid_d = 1'b0;
                    end
                end
`endif
                ST_HI: begin
                    // Head stays in place until its high byte goes out, so HI never sees an empty FIFO.
                    data_d  = head[15:8];
                    valid_d = 1'b1;
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        push     = dump && (!full || pop);
        drop     = dump && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end
        // A dropped word outranks a clear on the same edge.
        ovf_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : ovf_q);
`ifdef TRACK_READBACK_TAG_EN
        seq_d = pop ? seq_q + 7'd1 : seq_q;
`endif
    end

    always_ff @(posedge clk) begin
        req_q <= rd_req;
        if (reset) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef TRACK_READBACK_TAG_EN
            seq_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef TRACK_READBACK_TAG_EN
            seq_q    <= seq_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= accumulator;
        end
    end

    assign rd_ack   = ack_q;
    assign rd_data  = data_q;
    assign rd_valid = valid_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_track_readback.sv
// Testbench for track_readback: directed scenarios plus randomized traffic against a queue-based model.
module tb_track_readback;

    localparam int DEPTH = 16;
`ifdef TRACK_READBACK_TAG_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dump = 1'b0;
    logic [15:0] accumulator = 16'h0000;
    logic        rd_req = 1'b0;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        overflow;
    logic        clear_overflow = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] m_q[$];
    int          m_phase;
    int          m_seq;
    logic        m_ovf;
    logic        m_ack;
    logic [7:0]  m_data;
    logic        m_valid;

    track_readback #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .dump(dump), .accumulator(accumulator),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] frame_byte(input logic [15:0] w, input int ph, input logic ovf, input int seq);
        if (NB == 3 && ph == 0) return {ovf, 7'(seq)};
        if (ph == NB - 2) return w[7:0];
        return w[15:8];
    endfunction

    // Drive one cycle's inputs just after a rising edge, advance the model, then land 1ns past the next edge.
    task automatic step(input logic d, input logic [15:0] acc, input logic tog, input logic clr);
        logic pop;
        logic drop;
        dump = d;
        accumulator = acc;
        clear_overflow = clr;
        if (tog) rd_req = ~rd_req;
        pop = 1'b0;
        if (tog) begin
            m_ack = ~m_ack;
            if (m_phase == 0 && m_q.size() == 0) begin
                m_data = 8'h00;
                m_valid = 1'b0;
            end else begin
                m_data = frame_byte(m_q[0], m_phase, m_ovf, m_seq);
                m_valid = 1'b1;
                m_phase++;
                if (m_phase == NB) begin
                    pop = 1'b1;
                    m_phase = 0;
                end
            end
        end
        drop = d && (m_q.size() == DEPTH) && !pop;
        if (pop) begin
            void'(m_q.pop_front());
            m_seq = (m_seq + 1) % 128;
        end
        if (d && !drop) m_q.push_back(acc);
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic req_level);
        reset = 1'b1;
        dump = 1'b0;
        clear_overflow = 1'b0;
        rd_req = req_level;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_q.delete();
        m_phase = 0;
        m_seq = 0;
        m_ovf = 1'b0;
        m_ack = 1'b0;
        m_data = 8'h00;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        tests_run++;
        if (rd_ack !== 1'b0 || count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: ack=%b count=%0d valid=%b data=%h ovf=%b, want 0 0 0 00 0",
                     rd_ack, count, rd_valid, rd_data, overflow);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0);
            tests_run++;
            if (rd_ack !== 1'b0 || count !== 5'd0 || rd_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_spurious cycle %0d: ack=%b count=%0d valid=%b, want 0 0 0",
                         i, rd_ack, count, rd_valid);
            end
        end
    endtask

    task automatic test_basic_read();
        logic [7:0] want [2] = '{8'hEF, 8'hBE};
        logic [4:0] want_cnt [2] = '{5'd1, 5'd0};
        do_reset(1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        tests_run++;
        if (count !== 5'd1) begin
            tests_failed++;
            $display("FAIL basic_count_after_dump: got %0d want 1", count);
        end
        for (int b = 0; b < NB; b++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            if (b >= NB - 2) begin
                tests_run++;
                if (rd_data !== want[b - (NB - 2)] || rd_valid !== 1'b1 || count !== want_cnt[b - (NB - 2)] || rd_ack !== rd_req) begin
                    tests_failed++;
                    $display("FAIL basic_byte%0d: data=%h valid=%b count=%0d ack=%b req=%b, want %h 1 %0d ack==req",
                             b, rd_data, rd_valid, count, rd_ack, rd_req, want[b - (NB - 2)], want_cnt[b - (NB - 2)]);
                end
            end
        end
    endtask

    task automatic test_empty_read();
        logic ack_before;
        do_reset(1'b0);
        ack_before = rd_ack;
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        tests_run++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || rd_ack !== ~ack_before) begin
            tests_failed++;
            $display("FAIL empty_read: data=%h valid=%b ack=%b, want 00 0 %b", rd_data, rd_valid, rd_ack, ~ack_before);
        end
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        for (int b = 0; b < NB; b++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            if (b == NB - 2) begin
                tests_run++;
                if (rd_data !== 8'h34 || rd_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL empty_then_lo: data=%h valid=%b, want 34 1", rd_data, rd_valid);
                end
            end else if (b == NB - 1) begin
                tests_run++;
                if (rd_data !== 8'h12 || rd_valid !== 1'b1 || count !== 5'd0) begin
                    tests_failed++;
                    $display("FAIL empty_then_hi: data=%h valid=%b count=%0d, want 12 1 0", rd_data, rd_valid, count);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] want;
        do_reset(1'b0);
        for (int i = 0; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        tests_run++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_fill: count=%0d ovf=%b, want 16 1", count, overflow);
        end
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < NB; b++) begin
                step(1'b0, 16'h0000, 1'b1, 1'b0);
                if (b == NB - 2) want = 8'(w);
                else if (b == NB - 1) want = 8'h00;
                else want = {1'b1, 7'(w)};
                tests_run++;
                if (rd_data !== want || rd_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL overflow_drain w%0d b%0d: data=%h valid=%b, want %h 1", w, b, rd_data, rd_valid, want);
                end
            end
        end
        tests_run++;
        if (count !== 5'd0) begin
            tests_failed++;
            $display("FAIL overflow_drained_count: got %0d want 0", count);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        for (int b = 0; b < NB - 1; b++) step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'hCAFE, 1'b1, 1'b0);
        tests_run++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_data !== 8'h01) begin
            tests_failed++;
            $display("FAIL full_push_pop: count=%0d ovf=%b data=%h, want 16 0 01", count, overflow, rd_data);
        end
        for (int k = 0; k < 16 * NB; k++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            if (k == 16 * NB - 2) begin
                tests_run++;
                if (rd_data !== 8'hFE) begin
                    tests_failed++;
                    $display("FAIL full_last_lo: got %h want FE", rd_data);
                end
            end
        end
        tests_run++;
        if (rd_data !== 8'hCA || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL full_last_hi: data=%h count=%0d, want CA 0", rd_data, count);
        end
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1);
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL set_beats_clear: ovf=%b want 1", overflow);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        tests_run++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            tests_failed++;
            $display("FAIL clear_overflow: ovf=%b count=%0d, want 0 16", overflow, count);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset(1'b0);
        step(1'b1, 16'h5566, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        do_reset(rd_req);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        tests_run++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || count !== 5'd0 || rd_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_word: data=%h valid=%b count=%0d ack=%b, want 00 0 0 1",
                     rd_data, rd_valid, count, rd_ack);
        end
    endtask

`ifdef TRACK_READBACK_TAG_EN
    task automatic test_tag();
        logic [7:0] want [6] = '{8'h00, 8'h5A, 8'hA5, 8'h01, 8'h02, 8'h01};
        do_reset(1'b0);
        step(1'b1, 16'hA55A, 1'b0, 1'b0);
        step(1'b1, 16'h0102, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            tests_run++;
            if (rd_data !== want[k] || rd_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL tag_byte%0d: data=%h valid=%b, want %h 1", k, rd_data, rd_valid, want[k]);
            end
        end
        for (int i = 0; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        tests_run++;
        if (rd_data !== 8'h82) begin
            tests_failed++;
            $display("FAIL tag_overflow: got %h want 82", rd_data);
        end
    endtask
`endif

    task automatic test_random();
        logic d;
        logic tog;
        logic clr;
        do_reset(1'b0);
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(rd_req);
            if ((i / 150) % 2 == 0) begin
                d = $urandom_range(0, 2) != 0;
                tog = $urandom_range(0, 2) == 0;
            end else begin
                d = $urandom_range(0, 2) == 0;
                tog = $urandom_range(0, 2) != 0;
            end
            clr = $urandom_range(0, 15) == 0;
            step(d, 16'($urandom), tog, clr);
            tests_run++;
            if (rd_ack !== m_ack || rd_data !== m_data || rd_valid !== m_valid ||
                count !== 5'(m_q.size()) || overflow !== m_ovf) begin
                tests_failed++;
                $display("FAIL random cycle %0d: ack=%b data=%h valid=%b count=%0d ovf=%b, want %b %h %b %0d %b",
                         i, rd_ack, rd_data, rd_valid, count, overflow, m_ack, m_data, m_valid, m_q.size(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_empty_read();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_word();
`ifdef TRACK_READBACK_TAG_EN
        test_tag();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
